// File: rtl/ped_crossing_ctrl.sv
// Pedestrian-crossing controller fed by traffic_lights: grants walk only on plain red, with a sticky illegal-light fault.
// Optional macro PED_COUNTDOWN_EN adds a countdown output showing remaining walk/flash cycles.
module ped_crossing_ctrl #(
  parameter int WALK_CYCLES  = 8,
  parameter int FLASH_CYCLES = 6,
  parameter int FLASH_HALF   = 1,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             red,
  input  logic             amber,
  input  logic             green,
  input  logic             button,
  output logic             walk,
  output logic             dont_walk,
  output logic             wait_lamp,
`ifdef PED_COUNTDOWN_EN
  output logic [CNT_W-1:0] countdown,
`endif
  output logic             fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WALK  = 2'd1,
    FLASH = 2'd2,
    CLEAR = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_CYCLES);
  localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_CYCLES);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(FLASH_HALF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] half_reg, half_next;
  logic             pending_reg, pending_next;
  logic             walk_reg, walk_next;
  logic             dont_walk_reg, dont_walk_next;
  logic             fault_reg, fault_next;

  logic [2:0] code;
  logic       code_legal;
  logic       plain_red;
  logic       request;
  logic       abort;

  assign code       = {red, amber, green};
  assign code_legal = (code == 3'b100) || (code == 3'b110) ||
                      (code == 3'b001) || (code == 3'b010);
  assign plain_red  = (code == 3'b100);
  // A press on the granting edge counts as a request on that same edge.
  assign request    = pending_reg | button;

  always_comb begin
    fault_next     = fault_reg | ~code_legal;
    abort          = ~plain_red | fault_next;
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    half_next      = half_reg;
    pending_next   = request;
    walk_next      = 1'b0;
    dont_walk_next = 1'b1;

    case (state_reg)
      IDLE: begin
        if (request && plain_red && !fault_next) begin
          state_next     = WALK;
          cnt_next       = WALK_LOAD;
          pending_next   = 1'b0;
          walk_next      = 1'b1;
          dont_walk_next = 1'b0;
        end
      end

      WALK: begin
        if (abort) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_ONE) begin
          // Flash always opens in its dark phase.
          state_next     = FLASH;
          cnt_next       = FLASH_LOAD;
          half_next      = '0;
          dont_walk_next = 1'b0;
        end else begin
          cnt_next       = cnt_reg - CNT_ONE;
          walk_next      = 1'b1;
          dont_walk_next = 1'b0;
        end
      end

      FLASH: begin
        if (abort || (cnt_reg == CNT_ONE)) begin
          state_next = CLEAR;
          cnt_next   = '0;
          half_next  = '0;
        end else begin
          cnt_next       = cnt_reg - CNT_ONE;
          dont_walk_next = 1'b0;
          if (half_reg == HALF_LAST) begin
            half_next = '0;
            walk_next = ~walk_reg;
          end else begin
            half_next = half_reg + CNT_ONE;
            walk_next = walk_reg;
          end
        end
      end

      CLEAR: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        half_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      half_reg      <= '0;
      pending_reg   <= 1'b0;
      walk_reg      <= 1'b0;
      dont_walk_reg <= 1'b1;
      fault_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      half_reg      <= half_next;
      pending_reg   <= pending_next;
      walk_reg      <= walk_next;
      dont_walk_reg <= dont_walk_next;
      fault_reg     <= fault_next;
    end
  end

  assign walk      = walk_reg;
  assign dont_walk = dont_walk_reg;
  assign wait_lamp = pending_reg;
  assign fault     = fault_reg;

`ifdef PED_COUNTDOWN_EN
  // The phase counter already holds the remaining cycles and is zero outside WALK/FLASH.
  assign countdown = cnt_reg;
`endif

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Directed self-checking bench for ped_crossing_ctrl at default parameters.
module tb_ped_crossing_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic red, amber, green, button;
  logic walk, dont_walk, wait_lamp, fault;
`ifdef PED_COUNTDOWN_EN
  logic [7:0] countdown;
`endif

  int total  = 0;
  int passed = 0;

  ped_crossing_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .red       (red),
    .amber     (amber),
    .green     (green),
    .button    (button),
    .walk      (walk),
    .dont_walk (dont_walk),
    .wait_lamp (wait_lamp),
`ifdef PED_COUNTDOWN_EN
    .countdown (countdown),
`endif
    .fault     (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic lamps(input string tag, input logic w, input logic dw, input logic wl, input logic f);
    chk({tag, ".walk"}, {7'd0, walk}, {7'd0, w});
    chk({tag, ".dont_walk"}, {7'd0, dont_walk}, {7'd0, dw});
    chk({tag, ".wait_lamp"}, {7'd0, wait_lamp}, {7'd0, wl});
    chk({tag, ".fault"}, {7'd0, fault}, {7'd0, f});
    $display("step %-14s code=%b%b%b btn=%b -> walk=%b dont_walk=%b wait=%b fault=%b",
             tag, red, amber, green, button, walk, dont_walk, wait_lamp, fault);
  endtask

  task automatic cd(input string tag, input int exp);
`ifdef PED_COUNTDOWN_EN
    chk({tag, ".countdown"}, countdown, 8'(exp));
`else
    if (exp < 0) $display("unexpected countdown request %s", tag);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_code(input logic [2:0] c);
    {red, amber, green} = c;
  endtask

  initial begin
    rst_n = 1'b0;
    button = 1'b0;
    set_code(3'b001);
    repeat (2) step();
    lamps("reset", 1'b0, 1'b1, 1'b0, 1'b0);
    cd("reset", 0);
    rst_n = 1'b1;

    // Request latched while traffic has green: lamp lit, no walk.
    button = 1'b1;
    step();
    lamps("press_green", 1'b0, 1'b1, 1'b1, 1'b0);
    button = 1'b0;
    repeat (2) step();
    lamps("hold_green", 1'b0, 1'b1, 1'b1, 1'b0);

    // Normal grant: 8 walk, 6 flash (0,1,0,1,0,1), clear, idle.
    set_code(3'b100);
    for (int i = 0; i < 8; i++) begin
      step();
      lamps($sformatf("walk%0d", i), 1'b1, 1'b0, 1'b0, 1'b0);
      cd($sformatf("walk%0d", i), 8 - i);
    end
    for (int j = 0; j < 6; j++) begin
      step();
      lamps($sformatf("flash%0d", j), (j % 2 == 1), 1'b0, 1'b0, 1'b0);
      cd($sformatf("flash%0d", j), 6 - j);
    end
    step();
    lamps("clear", 1'b0, 1'b1, 1'b0, 1'b0);
    cd("clear", 0);
    repeat (2) step();
    lamps("idle_no_req", 1'b0, 1'b1, 1'b0, 1'b0);
    cd("idle", 0);

    // Button on the edge red first appears: granted on that edge.
    set_code(3'b001);
    step();
    set_code(3'b100);
    button = 1'b1;
    step();
    button = 1'b0;
    lamps("simul_grant", 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (7) step();
    lamps("walk_last", 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    lamps("flash_first", 1'b0, 1'b0, 1'b0, 1'b0);
    button = 1'b1;
    step();
    button = 1'b0;
    lamps("flash_press", 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (4) step();
    lamps("flash_last", 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    lamps("clear_pend", 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    lamps("idle_pend", 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    lamps("regrant", 1'b1, 1'b0, 1'b0, 1'b0);

    // Abort in walk cycle 3 on amber: straight to clear, no flash.
    repeat (2) step();
    lamps("walk_c3", 1'b1, 1'b0, 1'b0, 1'b0);
    cd("walk_c3", 6);
    set_code(3'b110);
    step();
    lamps("abort", 1'b0, 1'b1, 1'b0, 1'b0);
    cd("abort", 0);
    step();
    lamps("abort_idle", 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) step();
    lamps("abort_noflash", 1'b0, 1'b1, 1'b0, 1'b0);

    // Illegal code sets a sticky fault that blocks grants.
    set_code(3'b111);
    step();
    lamps("fault_set", 1'b0, 1'b1, 1'b0, 1'b1);
    set_code(3'b100);
    button = 1'b1;
    step();
    button = 1'b0;
    lamps("fault_press", 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (4) step();
    lamps("fault_block", 1'b0, 1'b1, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    lamps("fault_reset", 1'b0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Asynchronous reset in the middle of walk.
    button = 1'b1;
    step();
    button = 1'b0;
    lamps("walk_again", 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    #2 rst_n = 1'b0;
    #1;
    lamps("async_rst", 1'b0, 1'b1, 1'b0, 1'b0);
    cd("async_rst", 0);
    step();
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end
endmodule
